sram_controller: RTL and testbench

Memory-side responder for the pipeline's MEM stage. Accepts one 32-bit load or store per request, using the address, store data and read/write enables the EXE stage forwards into MEM. Performs the access as two 16-bit halves on the external SRAM. Holds `ready` low until the access completes, so the hazard/freeze logic stalls the pipeline for the duration.

---
 rtl/sram_controller.sv | 109 ++++++++++
 tb/tb_sram_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - MEM-stage responder doing one 32-bit load/store as two 16-bit SRAM halves
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [2:0] {IDLE, ACC_LO, ACC_HI, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [16:0] hw_index;
  logic        req;
  logic        load;
  logic        dq_oe;
  logic [15:0] dq_out;

  // Offset wraps modulo 2^32; only the word index bits reach the SRAM.
  assign hw_index = 17'((address - 32'(BASE_ADDR)) >> 2);
  assign req      = wr_en | rd_en;
  assign load     = rd_en & ~wr_en;
  assign ready    = ~req | (state == DONE);

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      readData <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req) state <= ACC_LO;
        ACC_LO: begin
          if (!req) begin
            state <= IDLE;
          end else begin
            if (load) readData[15:0] <= SRAM_DQ;
            state <= ACC_HI;
          end
        end
        ACC_HI: begin
          if (!req) begin
            state <= IDLE;
          end else begin
            if (load) readData[31:16] <= SRAM_DQ;
            wait_cnt <= 4'd0;
            state    <= (WAIT_CYCLES == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    SRAM_WE_N = 1'b1;
    SRAM_ADDR = 18'd0;
    dq_oe     = 1'b0;
    dq_out    = 16'd0;
    case (state)
      ACC_LO: begin
        SRAM_ADDR = {hw_index, 1'b0};
        SRAM_WE_N = ~wr_en;
        dq_oe     = wr_en;
        dq_out    = writeData[15:0];
      end
      ACC_HI: begin
        SRAM_ADDR = {hw_index, 1'b1};
        SRAM_WE_N = ~wr_en;
        dq_oe     = wr_en;
        dq_out    = writeData[31:16];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed bench for sram_controller with a behavioural SRAM model
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, rd_en, preload;
  logic [31:0] address, write_data;
  wire  [31:0] read_data;
  wire         ready;
  wire  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  logic        wr_en0, rd_en0;
  logic [31:0] address0, write_data0;
  wire  [31:0] read_data0;
  wire         ready0;
  wire  [15:0] sram_dq0;
  wire  [17:0] sram_addr0;
  wire         sram_we_n0, sram_ub_n0, sram_lb_n0, sram_ce_n0, sram_oe_n0;

  int tests = 0;
  int fails = 0;

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .writeData(write_data), .readData(read_data), .ready(ready), .SRAM_DQ(sram_dq),
    .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n), .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n), .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n)
  );

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
    .writeData(write_data0), .readData(read_data0), .ready(ready0), .SRAM_DQ(sram_dq0),
    .SRAM_ADDR(sram_addr0), .SRAM_WE_N(sram_we_n0), .SRAM_UB_N(sram_ub_n0),
    .SRAM_LB_N(sram_lb_n0), .SRAM_CE_N(sram_ce_n0), .SRAM_OE_N(sram_oe_n0)
  );

  // SRAM model: OE tied low, so it drives the bus whenever WE_N is high.
  logic [15:0] mem [0:15];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
      mem[2]  <= 16'h1234;
      mem[3]  <= 16'hABCD;
      mem[13] <= 16'hCAFE;
    end else if (!sram_we_n) begin
      mem[sram_addr[3:0]] <= sram_dq;
    end
  end
  assign sram_dq  = sram_we_n  ? mem[sram_addr[3:0]] : 16'hzzzz;
  assign sram_dq0 = sram_we_n0 ? (sram_addr0[15:0] ^ 16'hA5A5) : 16'hzzzz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic w,
                           input logic r, output logic [5:0] rv, output logic [17:0] a1,
                           output logic [17:0] a2, output logic [15:0] d1,
                           output logic [15:0] d2, output logic we1, output logic we2,
                           output logic [31:0] rd5);
    @(posedge clk); #1;
    address = a; write_data = wd; wr_en = w; rd_en = r;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      rv[t] = ready;
      if (t == 1) begin a1 = sram_addr; d1 = sram_dq; we1 = sram_we_n; end
      if (t == 2) begin a2 = sram_addr; d2 = sram_dq; we2 = sram_we_n; end
      if (t == 5) rd5 = read_data;
      if (t < 5) @(posedge clk);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  logic [5:0]  rv;
  logic [3:0]  rv0;
  logic [17:0] a1, a2;
  logic [15:0] d1, d2;
  logic        we1, we2;
  logic [31:0] rd5, rd0;

  initial begin
    rst = 1'b1; preload = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    address = 32'd0; write_data = 32'd0;
    wr_en0 = 1'b0; rd_en0 = 1'b0; address0 = 32'd0; write_data0 = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; preload = 1'b0;

    @(negedge clk);
    check("reset_we_n", 32'(sram_we_n), 32'd1);
    check("reset_addr", 32'(sram_addr), 32'd0);
    check("reset_rdata", read_data, 32'd0);
    check("reset_ready", 32'(ready), 32'd1);

    // Store 0xDEADBEEF to 1024
    do_access(32'd1024, 32'hDEADBEEF, 1'b1, 1'b0, rv, a1, a2, d1, d2, we1, we2, rd5);
    check("st_ready_seq", 32'(rv), 32'b100000);
    check("st_lo_addr", 32'(a1), 32'd0);
    check("st_lo_dq", 32'(d1), 32'hBEEF);
    check("st_lo_we", 32'(we1), 32'd0);
    check("st_hi_addr", 32'(a2), 32'd1);
    check("st_hi_dq", 32'(d2), 32'hDEAD);
    check("st_hi_we", 32'(we2), 32'd0);
    check("st_rdata_kept", rd5, 32'd0);
    check("st_mem", {mem[1], mem[0]}, 32'hDEADBEEF);

    // Load from 1028
    do_access(32'd1028, 32'd0, 1'b0, 1'b1, rv, a1, a2, d1, d2, we1, we2, rd5);
    check("ld_ready_seq", 32'(rv), 32'b100000);
    check("ld_lo_addr", 32'(a1), 32'd2);
    check("ld_hi_addr", 32'(a2), 32'd3);
    check("ld_we", {30'd0, we2, we1}, 32'd3);
    check("ld_rdata", rd5, 32'hABCD1234);

    // Both enables high: store wins
    do_access(32'd1032, 32'h00000007, 1'b1, 1'b1, rv, a1, a2, d1, d2, we1, we2, rd5);
    check("both_addr", 32'(a1), 32'd4);
    check("both_dq", 32'(d1), 32'h0007);
    check("both_we", 32'(we1), 32'd0);
    check("both_rdata_kept", rd5, 32'hABCD1234);

    // Address below BASE_ADDR wraps
    do_access(32'd1020, 32'h12345678, 1'b1, 1'b0, rv, a1, a2, d1, d2, we1, we2, rd5);
    check("wrap_lo_addr", 32'(a1), 32'h3FFFE);
    check("wrap_hi_addr", 32'(a2), 32'h3FFFF);

    // WAIT_CYCLES=0 instance, load from 1024
    @(posedge clk); #1;
    address0 = 32'd1024; rd_en0 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      rv0[t] = ready0;
      if (t == 3) rd0 = read_data0;
      if (t < 3) @(posedge clk);
    end
    @(posedge clk); #1;
    rd_en0 = 1'b0;
    check("w0_ready_seq", 32'(rv0), 32'b1000);
    check("w0_rdata", rd0, 32'hA5A4A5A5);

    // Reset during ACC_HI of a store
    @(posedge clk); #1;
    address = 32'd1040; write_data = 32'h55556666; wr_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_acc_hi_addr", 32'(sram_addr), 32'd9);
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_rdata", read_data, 32'd0);
    do_access(32'd1040, 32'd0, 1'b0, 1'b1, rv, a1, a2, d1, d2, we1, we2, rd5);
    check("post_rst_ready_seq", 32'(rv), 32'b100000);
    check("post_rst_rdata", rd5, 32'h55556666);

    // Store aborted in ACC_LO
    @(posedge clk); #1;
    address = 32'd1048; write_data = 32'h77778888; wr_en = 1'b1;
    @(negedge clk);
    check("abort_t0_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("abort_t1_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_t2_we_n", 32'(sram_we_n), 32'd1);
    check("abort_t2_addr", 32'(sram_addr), 32'd0);
    check("abort_t2_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_t3_we_n", 32'(sram_we_n), 32'd1);
    do_access(32'd1048, 32'd0, 1'b0, 1'b1, rv, a1, a2, d1, d2, we1, we2, rd5);
    check("abort_hi_untouched", {16'd0, rd5[31:16]}, 32'h0000CAFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
